// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - dual-issue fetch front end: PC, 2-wide ROM requests, pair queue, redirect flush
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4,
  parameter int          ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr1,
  output logic [31:0]       if_instr2,
  output logic              if_valid2,
  output logic [31:0]       if_pc1,
  output logic [31:0]       if_pc2,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam int              PW        = $clog2(FQ_DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW-1:0]   DEPTH     = CW'(FQ_DEPTH);
  localparam logic [31:0]     NOP       = 32'h0000_0013;
  localparam logic [ROM_AW-1:0] LAST_WORD = '1;

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   last_pc1;
  logic [31:0]   last_pc2;
  logic          inflight;
  logic          epoch;
  logic          req_epoch;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0]   q_pc [FQ_DEPTH];
  logic [31:0]   q_i1 [FQ_DEPTH];
  logic [31:0]   q_i2 [FQ_DEPTH];
  logic          q_v2 [FQ_DEPTH];

  logic          head_valid;
  logic          issue;
  logic          push;
  logic          pop;
  logic          req_v2;

  assign rom_addr   = pc[ROM_AW+1:2];
  assign head_valid = (count != '0);
  // Credit includes the in-flight request so a response always has a free slot.
  assign issue      = ((count + CW'(inflight)) < DEPTH) && !redirect_valid;
  assign push       = inflight && (req_epoch == epoch) && !redirect_valid;
  assign pop        = head_valid && id_ready && !redirect_valid;
  assign req_v2     = (req_pc[ROM_AW+1:2] != LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC & ~32'd3;
      req_pc    <= '0;
      req_epoch <= 1'b0;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_pc1  <= '0;
      last_pc2  <= '0;
    end else begin
      if (redirect_valid) begin
        pc     <= redirect_pc & ~32'd3;
        epoch  <= ~epoch;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) pc <= pc + 32'd8;
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      inflight <= issue;
      if (issue) begin
        req_pc    <= pc;
        req_epoch <= epoch;
      end
      if (head_valid) begin
        last_pc1 <= q_pc[rd_ptr];
        last_pc2 <= q_pc[rd_ptr] + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= req_pc;
      q_i1[wr_ptr] <= rom_instr1;
      q_i2[wr_ptr] <= rom_instr2;
      q_v2[wr_ptr] <= req_v2;
    end
  end

  assign if_valid  = head_valid;
  assign if_valid2 = head_valid && q_v2[rd_ptr];
  assign if_instr1 = head_valid ? q_i1[rd_ptr] : NOP;
  assign if_instr2 = if_valid2 ? q_i2[rd_ptr] : NOP;
  assign if_pc1    = head_valid ? q_pc[rd_ptr] : last_pc1;
  assign if_pc2    = head_valid ? (q_pc[rd_ptr] + 32'd4) : last_pc2;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (head_valid && !id_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
